// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: buffers {a, b, op} commands in a small FIFO and feeds them one at a
// time to an external combinational ALU through registered operand/opcode outputs.
// Each result is captured one cycle after issue and held until the downstream
// side takes it.
// Optional feature: define ALU_CMD_SEQ_ZERO_FLAG_EN to add the res_zero output,
// which is captured alongside res_data and is high when the ALU result is zero.
module alu_cmd_seq #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_out,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic [2:0] res_op,
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
   output logic       res_zero,
`endif
   output logic       busy
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   state_t        state;
   logic          push;
   logic          pop;

   // Handshake and pop decisions are pure functions of registered state and inputs.
   assign cmd_ready = (count != FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (count != '0) &&
                      ((state == IDLE) || ((state == HOLD) && res_valid && res_ready));
   assign head      = mem[rd_ptr];
   assign busy      = (count != '0) || (state != IDLE);

   // Command storage: write the incoming command at the write pointer.
   // NOTE: the storage array has no reset; count and the pointers decide which
   // entries are live, so stale contents are never read out.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
      end
   end

   // FIFO bookkeeping: pointers wrap naturally at DEPTH (a power of two).
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sequencer: IDLE waits for a queued command, ISSUE lets the ALU settle for one
   // cycle, HOLD keeps the captured result until it is accepted downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
         res_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  alu_a  <= head.a;
                  alu_b  <= head.b;
                  alu_op <= head.op;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               res_data  <= alu_out;
               res_op    <= alu_op;
               res_valid <= 1'b1;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
               res_zero  <= (alu_out == 4'd0);
`endif
               state     <= HOLD;
            end
            HOLD: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  if (pop) begin
                     alu_a  <= head.a;
                     alu_b  <= head.b;
                     alu_op <= head.op;
                     state  <= ISSUE;
                  end else begin
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
